// File: rtl/step_pulse_gen_if.sv
// Step pulse generator control/status bundle.
// Master drives mode, button and halt; slave returns step and phase info.
interface step_pulse_gen_if;
  logic        manual_mode;
  logic        manual_btn;
  logic        halt;
  logic        step_en;
  logic        phase_valid;
  logic [1:0]  phase;
  logic [15:0] step_cnt;
  logic        btn_level;

  modport master (
    output manual_mode,
    output manual_btn,
    output halt,
    input  step_en,
    input  phase_valid,
    input  phase,
    input  step_cnt,
    input  btn_level
  );

  modport slave (
    input  manual_mode,
    input  manual_btn,
    input  halt,
    output step_en,
    output phase_valid,
    output phase,
    output step_cnt,
    output btn_level
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Single-clock step generator: interval timer or debounced button
// produces one-cycle step enables followed by four phase strobes.
module step_pulse_gen #(
  parameter logic [31:0] STEP_INTERVAL   = 32'h001AF080,
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd100000
) (
  input logic             raw_clk,
  input logic             rst,
  step_pulse_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PH0,
    PH1,
    PH2,
    PH3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  phase_nx;
  logic        issue;

  logic        b1;
  logic        btn_s;
  logic        lvl;
  logic        lvl_d;
  logic        mode_d;
  logic        pending;
  logic [31:0] db_cnt;
  logic [31:0] int_cnt;
  logic        mode_chg;
  logic        rise;
  logic        run;
  logic        wrap;

  logic        step_q;
  logic        pv_q;
  logic [1:0]  phase_q;
  logic [15:0] cnt_q;

  always_ff @(posedge raw_clk or posedge rst) begin
    if (rst) begin
      b1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      b1    <= bus.manual_btn;
      btn_s <= b1;
    end
  end

  // Level only flips after btn_s disagrees for DEBOUNCE_CYCLES straight
  always_ff @(posedge raw_clk or posedge rst) begin
    if (rst) begin
      lvl    <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DEBOUNCE_CYCLES - 32'd1) begin
      lvl    <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 32'd1;
    end
  end

  assign mode_chg = bus.manual_mode != mode_d;
  assign rise     = bus.manual_mode & lvl & ~lvl_d;
  assign run      = ~bus.manual_mode & ~bus.halt;
  assign wrap     = run && (int_cnt == STEP_INTERVAL - 32'd1);

  always_ff @(posedge raw_clk or posedge rst) begin
    if (rst) begin
      mode_d <= 1'b0;
      lvl_d  <= 1'b0;
    end else begin
      mode_d <= bus.manual_mode;
      lvl_d  <= lvl;
    end
  end

  always_ff @(posedge raw_clk or posedge rst) begin
    if (rst) begin
      int_cnt <= '0;
    end else if (mode_chg) begin
      int_cnt <= '0;
    end else if (run) begin
      int_cnt <= wrap ? 32'd0 : int_cnt + 32'd1;
    end
  end

  // One-deep request latch; a mode switch discards whatever is waiting
  always_ff @(posedge raw_clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (mode_chg) begin
      pending <= 1'b0;
    end else if (issue) begin
      pending <= 1'b0;
    end else if (rise || wrap) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge raw_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    phase_nx = 2'd0;
    unique case (state)
      IDLE: begin
        if (pending && !bus.halt) begin
          issue    = 1'b1;
          state_nx = PH0;
        end
      end
      PH0:     state_nx = PH1;
      PH1:     state_nx = PH2;
      PH2:     state_nx = PH3;
      PH3:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    unique case (state_nx)
      PH1:     phase_nx = 2'd1;
      PH2:     phase_nx = 2'd2;
      PH3:     phase_nx = 2'd3;
      default: phase_nx = 2'd0;
    endcase
  end

  // Outputs registered from next state so step_en lines up with PH0
  always_ff @(posedge raw_clk or posedge rst) begin
    if (rst) begin
      step_q  <= 1'b0;
      pv_q    <= 1'b0;
      phase_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      step_q  <= issue;
      pv_q    <= state_nx != IDLE;
      phase_q <= phase_nx;
      cnt_q   <= cnt_q + 16'(issue);
    end
  end

  assign bus.step_en     = step_q;
  assign bus.phase_valid = pv_q;
  assign bus.phase       = phase_q;
  assign bus.step_cnt    = cnt_q;
  assign bus.btn_level   = lvl;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios plus random stimulus,
// all compared every cycle against an event-history reference model.
module tb_step_pulse_gen;
  localparam int SI = 8;
  localparam int DB = 4;

  logic raw_clk = 1'b0;
  logic rst     = 1'b1;

  step_pulse_gen_if bus();

  step_pulse_gen #(
    .STEP_INTERVAL  (32'(SI)),
    .DEBOUNCE_CYCLES(32'(DB))
  ) dut (
    .raw_clk(raw_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 raw_clk = ~raw_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle index of the state, cycle of the last issued
  // step (phases are derived from the distance to it), plus request state.
  int          cyc;
  int          last_issue;
  int          r_int;
  int          r_run;
  logic        r_b1, r_bs, r_lvl, r_lvl_old, r_mode, r_pend;
  logic [15:0] r_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0h expected %0h at cycle %0d",
                 tag, got, exp, cyc);
    end
  endtask

  task automatic ref_reset();
    cyc        = 0;
    last_issue = -100;
    r_int      = 0;
    r_run      = 0;
    r_b1       = 0;
    r_bs       = 0;
    r_lvl      = 0;
    r_lvl_old  = 0;
    r_mode     = 0;
    r_pend     = 0;
    r_cnt      = 0;
  endtask

  task automatic ref_step(input logic mm, input logic btn, input logic hlt);
    bit idle, chg, rise, wrap, issue;
    idle  = (cyc - last_issue) >= 4;
    chg   = mm != r_mode;
    rise  = mm && r_lvl && !r_lvl_old;
    wrap  = !mm && !hlt && (r_int == SI - 1);
    issue = idle && r_pend && !hlt;
    if (chg || issue) r_pend = 0;
    else if (rise || wrap) r_pend = 1;
    if (chg) r_int = 0;
    else if (!mm && !hlt) r_int = (r_int == SI - 1) ? 0 : r_int + 1;
    if (issue) begin
      last_issue = cyc + 1;
      r_cnt      = r_cnt + 16'd1;
    end
    r_lvl_old = r_lvl;
    if (r_bs == r_lvl) r_run = 0;
    else if (r_run + 1 == DB) begin
      r_lvl = r_bs;
      r_run = 0;
    end else r_run++;
    r_bs   = r_b1;
    r_b1   = btn;
    r_mode = mm;
    cyc++;
  endtask

  task automatic check_outputs();
    int d;
    bit pv;
    d  = cyc - last_issue;
    pv = (d >= 0) && (d <= 3);
    chk("step_en", 32'(bus.step_en), 32'(d == 0));
    chk("phase_valid", 32'(bus.phase_valid), 32'(pv));
    chk("phase", 32'(bus.phase), pv ? 32'(d) : 32'd0);
    chk("step_cnt", 32'(bus.step_cnt), 32'(r_cnt));
    chk("btn_level", 32'(bus.btn_level), 32'(r_lvl));
  endtask

  task automatic tick(input logic mm, input logic btn, input logic hlt);
    bus.manual_mode = mm;
    bus.manual_btn  = btn;
    bus.halt        = hlt;
    ref_step(mm, btn, hlt);
    @(negedge raw_clk);
    check_outputs();
  endtask

  task automatic do_reset();
    bus.manual_mode = 0;
    bus.manual_btn  = 0;
    bus.halt        = 0;
    rst = 1;
    @(negedge raw_clk);
    @(negedge raw_clk);
    ref_reset();
    check_outputs();
    rst = 0;
  endtask

  int   first, prev, cnt, gaperr, seen, t0, lvl_at, step_at, k;
  logic rb, rm, rh;
  int   hold;

  initial begin
    bus.manual_mode = 0;
    bus.manual_btn  = 0;
    bus.halt        = 0;
    ref_reset();
    do_reset();

    // auto stepping from reset
    first = -1; prev = -1; cnt = 0; gaperr = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 0);
      if (bus.step_en) begin
        if (prev >= 0 && cyc - prev != SI) gaperr++;
        if (first < 0) first = cyc;
        prev = cyc;
        cnt++;
      end
    end
    chk("auto_first", 32'(first), 32'(SI + 1));
    chk("auto_pulses", 32'(cnt), 32'((40 - (SI + 1)) / SI + 1));
    chk("auto_gap", 32'(gaperr), 0);

    // short glitch in manual mode
    repeat (6) tick(1, 0, 0);
    t0 = int'(bus.step_cnt);
    seen = 0;
    repeat (DB - 1) begin
      tick(1, 1, 0);
      if (bus.btn_level) seen++;
    end
    repeat (12) begin
      tick(1, 0, 0);
      if (bus.btn_level) seen++;
    end
    chk("glitch_level", 32'(seen), 0);
    chk("glitch_steps", 32'(bus.step_cnt), 32'(t0));

    // real press, then release
    t0 = cyc + 2;
    lvl_at = -1; step_at = -1; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0);
      if (bus.btn_level && lvl_at < 0) lvl_at = cyc;
      if (bus.step_en) begin
        cnt++;
        if (step_at < 0) step_at = cyc;
      end
    end
    chk("db_latency", 32'(lvl_at - t0), 32'(DB));
    chk("manual_latency", 32'(step_at - lvl_at), 2);
    repeat (20) begin
      tick(1, 0, 0);
      if (bus.step_en) cnt++;
    end
    chk("manual_steps", 32'(cnt), 1);

    // halt freezes the interval counter
    for (int i = 0; i < 40 && !(r_mode == 0 && r_int == 5); i++)
      tick(0, 0, 0);
    chk("halt_setup", 32'(r_int), 5);
    cnt = 0;
    repeat (20) begin
      tick(0, 0, 1);
      if (bus.step_en) cnt++;
    end
    chk("halt_steps", 32'(cnt), 0);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick(0, 0, 0);
      if (bus.step_en) k = i;
    end
    chk("halt_resume", 32'(k), 32'(SI - 5 + 1));

    // request pending when halt rises is held until halt falls
    for (int i = 0; i < 20 && !r_pend; i++) tick(0, 0, 0);
    cnt = 0;
    repeat (10) begin
      tick(0, 0, 1);
      if (bus.step_en) cnt++;
    end
    chk("halt_pending_held", 32'(cnt), 0);
    tick(0, 0, 0);
    chk("halt_release_step", 32'(bus.step_en), 1);

    // mode toggle on the wrap edge
    for (int i = 0; i < 20 && r_int != SI - 1; i++) tick(0, 0, 0);
    t0 = int'(bus.step_cnt);
    tick(1, 0, 0);
    tick(0, 0, 0);
    k = 0;
    for (int i = 1; i <= 3 * SI && k == 0; i++) begin
      tick(0, 0, 0);
      if (bus.step_en) k = i;
    end
    chk("toggle_restart", 32'(k), 32'(SI + 1));
    chk("toggle_steps", 32'(bus.step_cnt), 32'(t0 + 1));

    // randomized stimulus
    rb = 0; rm = 0; rh = 0; hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        rb   = ($urandom_range(1, 0) == 1);
        hold = $urandom_range(14, 1);
      end else hold--;
      if ($urandom_range(149, 0) == 0) rm = ~rm;
      if (rh) rh = ($urandom_range(3, 0) != 0);
      else    rh = ($urandom_range(15, 0) == 0);
      tick(rm, rb, rh);
    end

    // asynchronous reset in the middle of a phase sequence
    k = 0;
    for (int i = 0; i < 40 && k == 0; i++) begin
      tick(0, 0, 0);
      if (bus.phase_valid && bus.phase == 2'd2) k = 1;
    end
    chk("ph2_found", 32'(k), 1);
    #2 rst = 1;
    #1;
    chk("rst_phase_valid", 32'(bus.phase_valid), 0);
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_step_cnt", 32'(bus.step_cnt), 0);
    chk("rst_step_en", 32'(bus.step_en), 0);
    @(negedge raw_clk);
    ref_reset();
    check_outputs();
    rst = 0;
    first = -1;
    for (int i = 0; i < 2 * SI; i++) begin
      tick(0, 0, 0);
      if (bus.step_en && first < 0) first = cyc;
    end
    chk("post_rst_first", 32'(first), 32'(SI + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
